luma_frame_stream: RTL and testbench

Parametrised successor to the camera-path grayscale stage. Streams one frame of RGB pixels from the SDRAM read port through a two-stage weighted-luma pipeline. Emits RGB passthrough, gray, inverted gray or thresholded black/white pixels with frame/line markers to downstream image processing and VGA. Adds a valid/ready handshake with backpressure on both sides, a runtime mode and threshold, rounding/saturating arithmetic, and a clean frame-done report.

---
 rtl/luma_pkg.sv | 32 +++
 rtl/luma_mac.sv | 170 +++++++++++++++++
 rtl/luma_frame_stream.sv | 205 ++++++++++++++++++++
 tb/tb_luma_frame_stream.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luma_pkg.sv
// luma_pkg
// Shared definitions for the luma frame streaming path: FSM state and
// output-mode enumerations plus the default channel width, fractional
// precision and luma weights (BT.601-style, scaled by 2^FRAC_W).
package luma_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_W_R    = 77;
  localparam int DEF_W_G    = 150;
  localparam int DEF_W_B    = 29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_RGB  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_BW   = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  // Counter width that stays legal for degenerate 1-pixel dimensions.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/luma_mac.sv
// luma_mac
// Two-stage weighted-luma datapath. Stage 1 registers the three weighted
// channel products alongside the raw RGB and an opaque sideband bundle.
// Stage 2 sums the products, rounds half-up, drops the fractional bits and
// saturates to the channel range. Both stages share one stall enable that
// freezes the pipe whenever the stage-2 pixel is valid but not taken.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid, i_red/green/blue    pixel entering stage 1 (already accepted)
//   i_side                       sideband that travels with the pixel
//   i_ready                      downstream ready
//   o_adv                        pipeline advance enable
//   o_valid, o_y, o_red/green/blue, o_side   stage-2 results
module luma_mac
  import luma_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int W_R    = DEF_W_R,
  parameter int W_G    = DEF_W_G,
  parameter int W_B    = DEF_W_B,
  parameter int SIDE_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_red,
  input  logic [DATA_W-1:0] i_green,
  input  logic [DATA_W-1:0] i_blue,
  input  logic [SIDE_W-1:0] i_side,
  input  logic              i_ready,
  output logic              o_adv,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_y,
  output logic [DATA_W-1:0] o_red,
  output logic [DATA_W-1:0] o_green,
  output logic [DATA_W-1:0] o_blue,
  output logic [SIDE_W-1:0] o_side
);

  localparam int PROD_W = DATA_W + FRAC_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int YW_W   = SUM_W - FRAC_W;

  localparam logic [PROD_W-1:0] WR = PROD_W'(W_R);
  localparam logic [PROD_W-1:0] WG = PROD_W'(W_G);
  localparam logic [PROD_W-1:0] WB = PROD_W'(W_B);
  localparam logic [SUM_W-1:0]  ROUND_HALF = SUM_W'(2 ** (FRAC_W - 1));
  localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};

  logic              adv;

  logic              s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0] p_r_q, p_r_d;
  logic [PROD_W-1:0] p_g_q, p_g_d;
  logic [PROD_W-1:0] p_b_q, p_b_d;
  logic [DATA_W-1:0] s1_red_q, s1_red_d;
  logic [DATA_W-1:0] s1_green_q, s1_green_d;
  logic [DATA_W-1:0] s1_blue_q, s1_blue_d;
  logic [SIDE_W-1:0] s1_side_q, s1_side_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_y_q, s2_y_d;
  logic [DATA_W-1:0] s2_red_q, s2_red_d;
  logic [DATA_W-1:0] s2_green_q, s2_green_d;
  logic [DATA_W-1:0] s2_blue_q, s2_blue_d;
  logic [SIDE_W-1:0] s2_side_q, s2_side_d;

  logic [SUM_W-1:0]  sum;
  logic [YW_W-1:0]   y_wide;
  logic [DATA_W-1:0] y_sat;

  // A full stage 2 that downstream refuses blocks the whole pipe.
  assign adv   = !(s2_valid_q && !i_ready);
  assign o_adv = adv;

  // Stage 1: data only loads for real pixels so bubbles leave it untouched.
  always_comb begin
    s1_valid_d = s1_valid_q;
    p_r_d      = p_r_q;
    p_g_d      = p_g_q;
    p_b_d      = p_b_q;
    s1_red_d   = s1_red_q;
    s1_green_d = s1_green_q;
    s1_blue_d  = s1_blue_q;
    s1_side_d  = s1_side_q;
    if (adv) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        p_r_d      = PROD_W'(i_red) * WR;
        p_g_d      = PROD_W'(i_green) * WG;
        p_b_d      = PROD_W'(i_blue) * WB;
        s1_red_d   = i_red;
        s1_green_d = i_green;
        s1_blue_d  = i_blue;
        s1_side_d  = i_side;
      end
    end
  end

  // Two guard bits in the sum absorb the carry of three products plus the
  // rounding constant; anything left above DATA_W after the shift saturates.
  always_comb begin
    sum    = SUM_W'(p_r_q) + SUM_W'(p_g_q) + SUM_W'(p_b_q) + ROUND_HALF;
    y_wide = YW_W'(sum >> FRAC_W);
    y_sat  = (|y_wide[YW_W-1:DATA_W]) ? MAX_VAL : y_wide[DATA_W-1:0];
  end

  // Stage 2: holds its contents while stalled so outputs stay stable.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_red_d   = s2_red_q;
    s2_green_d = s2_green_q;
    s2_blue_d  = s2_blue_q;
    s2_side_d  = s2_side_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d     = y_sat;
        s2_red_d   = s1_red_q;
        s2_green_d = s1_green_q;
        s2_blue_d  = s1_blue_q;
        s2_side_d  = s1_side_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      p_r_q      <= '0;
      p_g_q      <= '0;
      p_b_q      <= '0;
      s1_red_q   <= '0;
      s1_green_q <= '0;
      s1_blue_q  <= '0;
      s1_side_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_red_q   <= '0;
      s2_green_q <= '0;
      s2_blue_q  <= '0;
      s2_side_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p_r_q      <= p_r_d;
      p_g_q      <= p_g_d;
      p_b_q      <= p_b_d;
      s1_red_q   <= s1_red_d;
      s1_green_q <= s1_green_d;
      s1_blue_q  <= s1_blue_d;
      s1_side_q  <= s1_side_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_red_q   <= s2_red_d;
      s2_green_q <= s2_green_d;
      s2_blue_q  <= s2_blue_d;
      s2_side_q  <= s2_side_d;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_y     = s2_y_q;
  assign o_red   = s2_red_q;
  assign o_green = s2_green_q;
  assign o_blue  = s2_blue_q;
  assign o_side  = s2_side_q;

endmodule

// File: rtl/luma_frame_stream.sv
// luma_frame_stream
// Streams one frame of RGB pixels from the SDRAM read port through the
// two-stage luma pipeline and emits passthrough, gray, black/white or
// inverted gray pixels with sof/eol/eof markers.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_start, i_mode, i_threshold   frame request and settings (latched)
//   o_read_request                 one-cycle pulse to start the SDRAM read
//   i_valid/o_ready, i_red/green/blue     input pixel handshake
//   o_valid/i_ready, o_red/green/blue     output pixel handshake
//   o_bw                           Y below threshold, in every mode
//   o_sof, o_eol, o_eof            frame/line markers, qualified by o_valid
//   o_busy, o_frame_done           activity flag and end-of-frame pulse
module luma_frame_stream
  import luma_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int W_R     = DEF_W_R,
  parameter int W_G     = DEF_W_G,
  parameter int W_B     = DEF_W_B
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_threshold,
  output logic              o_read_request,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_red,
  input  logic [DATA_W-1:0] i_green,
  input  logic [DATA_W-1:0] i_blue,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_red,
  output logic [DATA_W-1:0] o_green,
  output logic [DATA_W-1:0] o_blue,
  output logic              o_bw,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int COL_W = cnt_width(FRAME_W);
  localparam int ROW_W = cnt_width(FRAME_H);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(FRAME_H - 1);
  localparam logic [DATA_W-1:0] MAX_VAL  = {DATA_W{1'b1}};

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic              adv;
  logic              accept;
  logic              in_sof, in_eol, in_eof;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_y, s2_red, s2_green, s2_blue;
  logic [2:0]        s2_side;
  logic              out_xfer;
  logic              frame_done;
  logic              dark;

  assign o_ready = (state_q == RUN) && adv;
  assign accept  = i_valid && o_ready;

  // Markers describe the pixel being accepted now and ride the pipe with it.
  assign in_sof = (col_q == '0) && (row_q == '0);
  assign in_eol = (col_q == LAST_COL);
  assign in_eof = in_eol && (row_q == LAST_ROW);

  luma_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .W_R    (W_R),
    .W_G    (W_G),
    .W_B    (W_B),
    .SIDE_W (3)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (accept),
    .i_red   (i_red),
    .i_green (i_green),
    .i_blue  (i_blue),
    .i_side  ({in_sof, in_eol, in_eof}),
    .i_ready (i_ready),
    .o_adv   (adv),
    .o_valid (s2_valid),
    .o_y     (s2_y),
    .o_red   (s2_red),
    .o_green (s2_green),
    .o_blue  (s2_blue),
    .o_side  (s2_side)
  );

  assign out_xfer = s2_valid && i_ready;

  // Frame sequencing; mode and threshold are captured once per frame so a
  // change on the inputs mid-frame cannot mix modes within one image.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    thr_d      = thr_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = REQ;
          mode_d  = mode_e'(i_mode);
          thr_d   = i_threshold;
        end
      end
      REQ: state_d = RUN;
      RUN: begin
        if (accept && in_eof) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_xfer && s2_side[0]) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel to accept; cleared while requesting
  // so every frame starts at the origin.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == REQ) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (in_eol) begin
        col_d = '0;
        row_d = in_eof ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_RGB;
      thr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Output mux works from registered stage-2 data and latched settings, so
  // everything it drives holds still while the consumer stalls.
  always_comb begin
    dark    = (s2_y < thr_q);
    o_red   = s2_red;
    o_green = s2_green;
    o_blue  = s2_blue;
    case (mode_q)
      MODE_GRAY: begin
        o_red   = s2_y;
        o_green = s2_y;
        o_blue  = s2_y;
      end
      MODE_BW: begin
        o_red   = dark ? '0 : MAX_VAL;
        o_green = dark ? '0 : MAX_VAL;
        o_blue  = dark ? '0 : MAX_VAL;
      end
      MODE_INV: begin
        o_red   = MAX_VAL - s2_y;
        o_green = MAX_VAL - s2_y;
        o_blue  = MAX_VAL - s2_y;
      end
      default: ;
    endcase
  end

  assign o_bw           = dark;
  assign o_valid        = s2_valid;
  assign o_sof          = s2_side[2];
  assign o_eol          = s2_side[1];
  assign o_eof          = s2_side[0];
  assign o_read_request = (state_q == REQ);
  assign o_busy         = (state_q != IDLE);
  assign o_frame_done   = frame_done;

endmodule

// File: tb/tb_luma_frame_stream.sv
// tb_luma_frame_stream
// Self-checking bench for luma_frame_stream on a 4x2 frame. A second
// instance with 255/255/255 weights shares all inputs to exercise
// saturation. Expected pixels come from an integer reference model of the
// luma formula and the mode rules.
module tb_luma_frame_stream;

  localparam int NPIX = 8;
  localparam int FW   = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [9:0]  i_threshold;
  logic        i_valid;
  logic        i_ready;
  logic [9:0]  i_red, i_green, i_blue;

  logic        o_read_request, o_ready, o_valid, o_bw;
  logic [9:0]  o_red, o_green, o_blue;
  logic        o_sof, o_eol, o_eof, o_busy, o_frame_done;

  logic        d2_read_request, d2_ready, d2_valid, d2_bw;
  logic [9:0]  d2_red, d2_green, d2_blue;
  logic        d2_sof, d2_eol, d2_eof, d2_busy, d2_frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  int pix_r[NPIX];
  int pix_g[NPIX];
  int pix_b[NPIX];

  always #5 i_clk = ~i_clk;

  luma_frame_stream #(.FRAME_W(FW), .FRAME_H(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_threshold(i_threshold), .o_read_request(o_read_request),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_bw(o_bw),
    .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  luma_frame_stream #(.FRAME_W(FW), .FRAME_H(2), .W_R(255), .W_G(255), .W_B(255)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_threshold(i_threshold), .o_read_request(d2_read_request),
    .i_valid(i_valid), .o_ready(d2_ready),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_valid(d2_valid), .i_ready(i_ready),
    .o_red(d2_red), .o_green(d2_green), .o_blue(d2_blue), .o_bw(d2_bw),
    .o_sof(d2_sof), .o_eol(d2_eol), .o_eof(d2_eof),
    .o_busy(d2_busy), .o_frame_done(d2_frame_done)
  );

  // Reference: Y = round-half-up(weighted sum / 256), clipped to 1023.
  // Returns {red, green, blue, bw}.
  function automatic logic [30:0] model(input int r, input int g, input int b,
                                        input int mode, input int thr,
                                        input int wr, input int wg, input int wb);
    int y;
    int v;
    logic bw;
    y = (r * wr + g * wg + b * wb + 128) / 256;
    if (y > 1023) y = 1023;
    bw = (y < thr);
    case (mode)
      0: return {10'(r), 10'(g), 10'(b), bw};
      1: v = y;
      2: v = bw ? 0 : 1023;
      default: v = 1023 - y;
    endcase
    return {10'(v), 10'(v), 10'(v), bw};
  endfunction

  task automatic fill_random(input int from);
    for (int i = from; i < NPIX; i++) begin
      pix_r[i] = $urandom_range(0, 1023);
      pix_g[i] = $urandom_range(0, 1023);
      pix_b[i] = $urandom_range(0, 1023);
    end
  endtask

  task automatic set_gray(input int idx, input int v);
    pix_r[idx] = v;
    pix_g[idx] = v;
    pix_b[idx] = v;
  endtask

  // Runs one frame from i_start to frame_done, checking every transfer
  // against the model and, when unstalled, the two-cycle latency.
  task automatic run_frame(input int mode, input int thr, input bit rnd_v,
                           input bit rnd_r, input bit poke);
    int in_idx, out_idx, rq_extra;
    int acc_cyc[NPIX];
    bit done_seen, stall_prev, chk_lat;
    logic [30:0] exp_pix, exp2;
    logic [34:0] saved, now_vec;
    in_idx = 0; out_idx = 0; rq_extra = 0;
    done_seen = 0; stall_prev = 0; saved = '0;
    chk_lat = !rnd_v && !rnd_r;
    @(negedge i_clk);
    i_start = 1'b1; i_mode = 2'(mode); i_threshold = 10'(thr);
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    n_checks++;
    if ({o_read_request, o_ready, o_busy} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL req_cycle: got rq/rdy/busy=%b required 101", {o_read_request, o_ready, o_busy});
    end
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      @(negedge i_clk);
      i_valid = (in_idx < NPIX) && (rnd_v ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (in_idx < NPIX) begin
        i_red = 10'(pix_r[in_idx]); i_green = 10'(pix_g[in_idx]); i_blue = 10'(pix_b[in_idx]);
      end else begin
        i_red = 10'($urandom); i_green = 10'($urandom); i_blue = 10'($urandom);
      end
      i_ready = rnd_r ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (poke && cyc == 3) begin
        i_start = 1'b1; i_mode = 2'(mode ^ 3); i_threshold = 10'($urandom);
      end else if (poke && cyc == 4) begin
        i_start = 1'b0;
      end
      #1;
      if (o_read_request) rq_extra++;
      now_vec = {o_valid, o_red, o_green, o_blue, o_bw, o_sof, o_eol, o_eof};
      if (stall_prev) begin
        n_checks++;
        if (now_vec !== saved) begin
          n_fail++;
          $display("[TB] FAIL stall_hold: got %h required %h", now_vec, saved);
        end
      end
      if (i_valid && o_ready) begin
        acc_cyc[in_idx] = cyc;
        in_idx++;
      end
      if (o_valid && i_ready) begin
        if (out_idx >= NPIX) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL extra_output: got output %0d required at most %0d", out_idx + 1, NPIX);
        end else begin
          exp_pix = model(pix_r[out_idx], pix_g[out_idx], pix_b[out_idx], mode, thr, 77, 150, 29);
          exp2    = model(pix_r[out_idx], pix_g[out_idx], pix_b[out_idx], mode, thr, 255, 255, 255);
          n_checks++;
          if ({o_red, o_green, o_blue, o_bw} !== exp_pix) begin
            n_fail++;
            $display("[TB] FAIL pix%0d_data: got %h required %h", out_idx, {o_red, o_green, o_blue, o_bw}, exp_pix);
          end
          n_checks++;
          if (d2_red !== exp2[30:21]) begin
            n_fail++;
            $display("[TB] FAIL pix%0d_sat_red: got %0d required %0d", out_idx, d2_red, exp2[30:21]);
          end
          n_checks++;
          if ({o_sof, o_eol, o_eof} !== {out_idx == 0, (out_idx % FW) == FW - 1, out_idx == NPIX - 1}) begin
            n_fail++;
            $display("[TB] FAIL pix%0d_markers: got %b required %b", out_idx, {o_sof, o_eol, o_eof},
                     {out_idx == 0, (out_idx % FW) == FW - 1, out_idx == NPIX - 1});
          end
          n_checks++;
          if (o_frame_done !== (out_idx == NPIX - 1)) begin
            n_fail++;
            $display("[TB] FAIL pix%0d_frame_done: got %b required %b", out_idx, o_frame_done, out_idx == NPIX - 1);
          end
          if (chk_lat) begin
            n_checks++;
            if (cyc - acc_cyc[out_idx] != 2) begin
              n_fail++;
              $display("[TB] FAIL pix%0d_latency: got %0d required 2", out_idx, cyc - acc_cyc[out_idx]);
            end
          end
          if (o_frame_done) done_seen = 1;
        end
        out_idx++;
      end else begin
        n_checks++;
        if (o_frame_done !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stray_frame_done: got %b required 0", o_frame_done);
        end
      end
      stall_prev = o_valid && !i_ready;
      saved = now_vec;
    end
    n_checks++;
    if (!done_seen || out_idx != NPIX) begin
      n_fail++;
      $display("[TB] FAIL frame_complete: got %0d outputs done=%0d required %0d done=1", out_idx, done_seen, NPIX);
    end
    n_checks++;
    if (rq_extra != 0) begin
      n_fail++;
      $display("[TB] FAIL read_request_extra: got %0d required 0", rq_extra);
    end
    if (chk_lat) begin
      n_checks++;
      if (acc_cyc[0] != 0) begin
        n_fail++;
        $display("[TB] FAIL first_accept_cycle: got %0d required 0", acc_cyc[0]);
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    n_checks++;
    if ({o_busy, o_valid, o_frame_done} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL post_frame_idle: got busy/valid/done=%b required 000", {o_busy, o_valid, o_frame_done});
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({o_ready, o_valid, o_read_request, o_busy, o_frame_done, o_bw, o_sof, o_eol, o_eof,
         o_red, o_green, o_blue, d2_red} !== '0) begin
      n_fail++;
      $display("[TB] FAIL %s: got rdy/val/rq/busy/done/bw/sof/eol/eof=%b rgb=%h,%h,%h required all 0",
               name, {o_ready, o_valid, o_read_request, o_busy, o_frame_done, o_bw, o_sof, o_eol, o_eof},
               o_red, o_green, o_blue);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    check_all_zero("reset_state");
    @(negedge i_clk);
    i_start = 1'b1; i_mode = 2'd1; i_threshold = 10'd600;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_ready = 1'b1;
      i_red = 10'($urandom); i_green = 10'($urandom); i_blue = 10'($urandom);
    end
    #1;
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midframe_valid: got %b required 1", o_valid);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    n_checks++;
    if (o_frame_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_done: got %b required 0", o_frame_done);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_all_zero("abort_state");
    i_valid = 1'b0;
    fill_random(0);
    run_frame(1, 512, 0, 0, 0);
  endtask

  task automatic test_arith();
    $display("[TB] test_arith");
    set_gray(0, 1023);
    pix_r[1] = 1023; pix_g[1] = 0; pix_b[1] = 0;
    set_gray(2, 512);
    pix_r[3] = 0; pix_g[3] = 0; pix_b[3] = 1023;
    fill_random(4);
    run_frame(1, 0, 0, 0, 0);
  endtask

  task automatic test_threshold();
    $display("[TB] test_threshold");
    fill_random(0);
    set_gray(0, 511);
    set_gray(1, 512);
    run_frame(2, 512, 0, 0, 0);
    fill_random(0);
    set_gray(2, 300);
    run_frame(3, $urandom_range(0, 1023), 0, 0, 0);
  endtask

  task automatic test_small_frame();
    $display("[TB] test_small_frame");
    fill_random(0);
    run_frame(0, $urandom_range(0, 1023), 0, 0, 0);
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    for (int rep = 0; rep < 4; rep++) begin
      int m;
      int t;
      m = $urandom_range(0, 3);
      t = $urandom_range(0, 1023);
      fill_random(0);
      run_frame(m, t, 0, 0, 0);
      run_frame(m, t, 1, 1, 0);
    end
  endtask

  task automatic test_start_ignored();
    $display("[TB] test_start_ignored");
    fill_random(0);
    run_frame(0, 100, 0, 0, 1);
    fill_random(0);
    run_frame(2, 700, 1, 1, 1);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_threshold = '0;
    i_valid = 1'b0; i_ready = 1'b1;
    i_red = '0; i_green = '0; i_blue = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    test_reset();
    test_arith();
    test_threshold();
    test_small_frame();
    test_backpressure();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
